// File: rtl/skey_reader_if.sv
// ROM read bus and key-word stream between skey_reader and its neighbours.
// master: the reader (drives ROM address/enable and the stream head).
// slave:  the ROM and the consumer side.
interface skey_reader_if #(
  parameter int ADDR_MSB = 3
);
  logic [ADDR_MSB:0] skey_addr;
  logic              skey_cen;
  logic [15:0]       skey_dout;
  logic [15:0]       key_word;
  logic [ADDR_MSB:0] key_idx;
  logic              key_last;
  logic              key_valid;
  logic              key_ready;

  modport master (
    output skey_addr, skey_cen, key_word, key_idx, key_last, key_valid,
    input  skey_dout, key_ready
  );

  modport slave (
    input  skey_addr, skey_cen, key_word, key_idx, key_last, key_valid,
    output skey_dout, key_ready
  );
endinterface

// File: rtl/skey_reader.sv
// Secret-key ROM read sequencer: walks ROM words 0..WORDS-1 after a start
// pulse and streams them out through a credit-controlled output FIFO.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for start; ROM disabled
// S_FETCH | issuing ROM reads whenever a FIFO slot is guaranteed
// S_DRAIN | all reads issued; waiting for the last word to transfer
// S_DONE  | one-cycle done pulse, then back to idle
module skey_reader #(
  parameter int ADDR_MSB   = 3,
  parameter int MEM_SIZE   = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic mclk,
  input  logic puc_rst,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done,
  skey_reader_if.master bus
);

  localparam int AW    = ADDR_MSB + 1;
  localparam int WORDS = MEM_SIZE / 2;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;
  localparam int SW    = CW + 1;

  localparam logic [AW-1:0] LAST_IDX = AW'(WORDS - 1);
  localparam logic [SW-1:0] DEPTH_S  = SW'(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [AW-1:0] issue_cnt_q, issue_cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          cen_q, cen_d;
  logic          s1_q, s1_d;
  logic [AW-1:0] s1_idx_q, s1_idx_d;
  logic          s2_q, s2_d;
  logic [AW-1:0] s2_idx_q, s2_idx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [15:0]           fifo_word_q [FIFO_DEPTH];
  logic [15:0]           fifo_word_d [FIFO_DEPTH];
  logic [AW-1:0]         fifo_idx_q  [FIFO_DEPTH];
  logic [AW-1:0]         fifo_idx_d  [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last_q, fifo_last_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;

  logic          key_valid;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          head_last;
  logic [SW-1:0] credit_used;
  logic          credit_ok;
  logic          issue;
  logic [AW-1:0] issue_idx;

  assign key_valid = (count_q != '0);
  assign fifo_push = s2_q;
  assign fifo_pop  = key_valid && bus.key_ready;
  assign fifo_full = (count_q == DEPTH_C);
  assign head_last = fifo_last_q[rd_ptr_q];

  // Words already buffered plus both reads in flight must fit in the FIFO;
  // a pop in the current cycle is deliberately not counted as a free slot.
  assign credit_used = SW'(count_q) + SW'(s1_q) + SW'(s2_q);
  assign credit_ok   = (credit_used < DEPTH_S);

  // Next-state logic: sequencing, read issue, read pipeline and FIFO.
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    addr_d      = addr_q;
    cen_d       = 1'b1;
    s1_d        = 1'b0;
    s1_idx_d    = s1_idx_q;
    s2_d        = s1_q;
    s2_idx_d    = s1_idx_q;
    fifo_word_d = fifo_word_q;
    fifo_idx_d  = fifo_idx_q;
    fifo_last_d = fifo_last_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    issue       = 1'b0;
    issue_idx   = (state_q == S_IDLE) ? '0 : issue_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_FETCH;
          issue_cnt_d = '0;
          issue       = credit_ok;
        end
      end
      S_FETCH: begin
        issue = credit_ok;
      end
      S_DRAIN: begin
        if (fifo_pop && head_last && !s1_q && !s2_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The counter stops at the last index instead of wrapping.
    if (issue) begin
      cen_d    = 1'b0;
      addr_d   = issue_idx;
      s1_d     = 1'b1;
      s1_idx_d = issue_idx;
      if (issue_idx == LAST_IDX) begin
        state_d = S_DRAIN;
      end else begin
        issue_cnt_d = issue_idx + AW'(1);
      end
    end

    if (fifo_push) begin
      fifo_word_d[wr_ptr_q] = bus.skey_dout;
      fifo_idx_d[wr_ptr_q]  = s2_idx_q;
      fifo_last_d[wr_ptr_q] = (s2_idx_q == LAST_IDX);
      wr_ptr_d              = wr_ptr_q + PW'(1);
    end
    if (fifo_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({fifo_push, fifo_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Abort discards everything buffered or still returning from the ROM.
    if (abort) begin
      state_d     = S_IDLE;
      issue_cnt_d = '0;
      cen_d       = 1'b1;
      s1_d        = 1'b0;
      s2_d        = 1'b0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
    end

    busy_d = (state_d == S_FETCH) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  // All state, including the FSM and registered outputs, updates here.
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state_q     <= S_IDLE;
      issue_cnt_q <= '0;
      addr_q      <= '0;
      cen_q       <= 1'b1;
      s1_q        <= 1'b0;
      s1_idx_q    <= '0;
      s2_q        <= 1'b0;
      s2_idx_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_word_q[i] <= '0;
        fifo_idx_q[i]  <= '0;
      end
      fifo_last_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      addr_q      <= addr_d;
      cen_q       <= cen_d;
      s1_q        <= s1_d;
      s1_idx_q    <= s1_idx_d;
      s2_q        <= s2_d;
      s2_idx_q    <= s2_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fifo_word_q <= fifo_word_d;
      fifo_idx_q  <= fifo_idx_d;
      fifo_last_q <= fifo_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // A push into a full FIFO without a matching pop means the credit rule broke.
  always_ff @(posedge mclk) begin
    if (!puc_rst) begin
      assert (!(fifo_push && !fifo_pop && fifo_full));
    end
  end

  assign bus.skey_addr = addr_q;
  assign bus.skey_cen  = cen_q;
  assign bus.key_word  = fifo_word_q[rd_ptr_q];
  assign bus.key_idx   = fifo_idx_q[rd_ptr_q];
  assign bus.key_last  = head_last;
  assign bus.key_valid = key_valid;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_skey_reader.sv
// Directed and randomized checks of skey_reader against a ROM model and a
// word-order reference derived from the key contents.
module tb_skey_reader;

  localparam int ADDR_MSB   = 3;
  localparam int MEM_SIZE   = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int WORDS      = MEM_SIZE / 2;
  localparam int ROM_WORDS  = 2 ** (ADDR_MSB + 1);

  logic mclk = 1'b0;
  logic puc_rst;
  logic start;
  logic abort;
  logic busy;
  logic done;

  skey_reader_if #(.ADDR_MSB(ADDR_MSB)) bus ();

  skey_reader #(
    .ADDR_MSB  (ADDR_MSB),
    .MEM_SIZE  (MEM_SIZE),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .mclk   (mclk),
    .puc_rst(puc_rst),
    .start  (start),
    .abort  (abort),
    .busy   (busy),
    .done   (done),
    .bus    (bus)
  );

  always #5 mclk = ~mclk;

  // ROM: registered address, data valid the cycle after an enabled edge.
  logic [15:0] rom [ROM_WORDS];
  logic [15:0] rom_dout;
  always @(posedge mclk) begin
    if (!bus.skey_cen) rom_dout <= rom[bus.skey_addr];
  end
  assign bus.skey_dout = rom_dout;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Observation: transfers, issued addresses, done pulses, busy cycles.
  logic [31:0] got_q [$];
  int          iss_q [$];
  int          n_done, n_busy, cyc, first_x, last_x, done_cyc;

  always @(negedge mclk) begin
    cyc = cyc + 1;
    if (!puc_rst) begin
      if (bus.key_valid && bus.key_ready) begin
        if (got_q.size() == 0) first_x = cyc;
        last_x = cyc;
        got_q.push_back({11'd0, bus.key_last, bus.key_idx, bus.key_word});
      end
      if (!bus.skey_cen) iss_q.push_back(int'(bus.skey_addr));
      if (done) begin
        n_done   = n_done + 1;
        done_cyc = cyc;
      end
      if (busy) n_busy = n_busy + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected stream entry k: {last, idx, word} with word = 0x1234*k mod 2^16.
  function automatic logic [31:0] exp_entry(input int k);
    logic [15:0] w;
    w = 16'(32'h1234 * k);
    return {11'd0, (k == WORDS - 1), 4'(k), w};
  endfunction

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic clear_obs();
    got_q.delete();
    iss_q.delete();
    n_done   = 0;
    n_busy   = 0;
    first_x  = 0;
    last_x   = 0;
    done_cyc = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit rnd, input int budget);
    int k;
    k = 0;
    while (n_done == 0 && k < budget) begin
      if (rnd) bus.key_ready = 1'($urandom_range(0, 1));
      step();
      k++;
    end
    chk({tag, ".finished"}, 32'(n_done != 0), 32'd1);
  endtask

  task automatic check_stream(input string tag);
    chk({tag, ".len"}, got_q.size(), WORDS);
    for (int k = 0; k < WORDS && k < got_q.size(); k++)
      chk({tag, ".word"}, got_q[k], exp_entry(k));
    chk({tag, ".issues"}, iss_q.size(), WORDS);
    for (int k = 0; k < WORDS && k < iss_q.size(); k++)
      chk({tag, ".addr"}, iss_q[k], k);
    chk({tag, ".ndone"}, n_done, 1);
    chk({tag, ".done_lat"}, done_cyc - last_x, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".valid"}, bus.key_valid, 0);
    chk({tag, ".word"},  bus.key_word, 0);
    chk({tag, ".idx"},   bus.key_idx, 0);
    chk({tag, ".last"},  bus.key_last, 0);
    chk({tag, ".cen"},   bus.skey_cen, 1);
    chk({tag, ".addr"},  bus.skey_addr, 0);
    chk({tag, ".busy"},  busy, 0);
    chk({tag, ".done"},  done, 0);
  endtask

  initial begin
    int k;
    for (int i = 0; i < ROM_WORDS; i++) rom[i] = 16'(32'h1234 * i);
    rom_dout      = 16'h0;
    cyc           = 0;
    clear_obs();
    puc_rst       = 1'b1;
    start         = 1'b0;
    abort         = 1'b0;
    bus.key_ready = 1'b0;

    // Reset state
    step(); step(); step();
    check_reset_vals("reset");
    puc_rst = 1'b0;
    step();

    // Full throughput with latency checks
    clear_obs();
    bus.key_ready = 1'b1;
    pulse_start();
    chk("lat.e0.busy", busy, 1);
    chk("lat.e0.cen", bus.skey_cen, 0);
    chk("lat.e0.addr", bus.skey_addr, 0);
    chk("lat.e0.valid", bus.key_valid, 0);
    step();
    chk("lat.e1.valid", bus.key_valid, 0);
    step();
    chk("lat.e2.valid", bus.key_valid, 1);
    chk("lat.e2.word", bus.key_word, 16'h0000);
    chk("lat.e2.idx", bus.key_idx, 0);
    wait_done("full", 1'b0, 100);
    check_stream("full");
    chk("full.back_to_back", last_x - first_x, WORDS - 1);
    chk("full.busy_cycles", n_busy, WORDS + 2);
    chk("full.idle_done", done, 0);
    chk("full.idle_busy", busy, 0);

    // Backpressure: consumer stalls for 10 cycles after the first valid
    clear_obs();
    bus.key_ready = 1'b0;
    pulse_start();
    step();
    step();
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp.valid", bus.key_valid, 1);
      chk("bp.word", bus.key_word, 16'h0000);
      chk("bp.idx", bus.key_idx, 0);
    end
    chk("bp.issued", iss_q.size(), FIFO_DEPTH);
    chk("bp.cen", bus.skey_cen, 1);
    bus.key_ready = 1'b1;
    wait_done("bp", 1'b0, 100);
    check_stream("bp");

    // Abort after five transfers
    clear_obs();
    bus.key_ready = 1'b1;
    pulse_start();
    k = 0;
    while (got_q.size() < 5 && k < 50) begin
      step();
      k++;
    end
    chk("abort.reached5", 32'(got_q.size() >= 5), 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort.valid", bus.key_valid, 0);
    chk("abort.cen", bus.skey_cen, 1);
    chk("abort.busy", busy, 0);
    chk("abort.done", done, 0);
    for (int i = 0; i < 5; i++) step();
    chk("abort.ndone", n_done, 0);
    chk("abort.quiet_valid", bus.key_valid, 0);
    clear_obs();
    pulse_start();
    wait_done("after_abort", 1'b0, 100);
    check_stream("after_abort");

    // Synchronous reset while draining
    clear_obs();
    bus.key_ready = 1'b1;
    pulse_start();
    k = 0;
    while (!(bus.skey_cen == 1'b0 && int'(bus.skey_addr) == WORDS - 1) && k < 50) begin
      step();
      k++;
    end
    chk("rst.reached_last_issue", 32'(k < 50), 1);
    puc_rst = 1'b1;
    step();
    check_reset_vals("rst_drain");
    puc_rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("rst.ndone", n_done, 0);
    chk("rst.valid", bus.key_valid, 0);

    // Start while busy is ignored
    clear_obs();
    bus.key_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 4; i++) step();
    pulse_start();
    wait_done("restart", 1'b0, 100);
    check_stream("restart");
    for (int i = 0; i < 5; i++) step();
    chk("restart.ndone_after", n_done, 1);
    chk("restart.busy_after", busy, 0);

    // Start together with abort in IDLE
    clear_obs();
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("sa.busy", busy, 0);
    chk("sa.cen", bus.skey_cen, 1);
    for (int i = 0; i < 3; i++) step();
    chk("sa.valid", bus.key_valid, 0);
    chk("sa.issued", iss_q.size(), 0);

    // Random consumer readiness
    for (int r = 0; r < 1000; r++) begin
      clear_obs();
      bus.key_ready = 1'($urandom_range(0, 1));
      pulse_start();
      wait_done("rnd", 1'b1, 400);
      check_stream("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
